// File: rtl/fb_write_sched_pkg.sv
// Shared types and display geometry for the framebuffer write scheduler.
package fb_pkg;

    localparam int FB_WORDS      = 9600;
    localparam int WORDS_PER_ROW = 20;
    localparam int DISPLAY_W     = 640;
    localparam int DISPLAY_H     = 480;

    typedef enum logic {
        OP_CLEAR = 1'b0,
        OP_FILL  = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_VBL = 2'd1,
        RUN      = 2'd2
    } state_e;

endpackage

// File: rtl/fb_write_sched_if.sv
// Avalon-MM host write port shared between the host (master) and the scheduler (slave).
interface fb_write_sched_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic              chipselect;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;

    modport master (
        output chipselect, write, address, writedata,
        input  waitrequest
    );

    modport slave (
        input  chipselect, write, address, writedata,
        output waitrequest
    );
endinterface

// File: rtl/fb_write_sched_grant.sv
// RAM-port arbiter: host priority with a starvation counter that guarantees
// the engine one slot after STARVE_LIMIT consecutive host wins.
module fb_grant #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic host_req_i,
    input  logic eng_req_i,
    output logic waitrequest_o,
    output logic host_gnt_o,
    output logic eng_gnt_o
);
    // One spare code so the counter can hold STARVE_LIMIT itself, even for a limit of 0.
    localparam int               CNT_W = $clog2(STARVE_LIMIT + 2);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic             eng_pend;

    assign eng_pend      = run_i && eng_req_i;
    assign waitrequest_o = eng_pend && (starve_q == LIMIT);
    assign host_gnt_o    = host_req_i && !waitrequest_o;
    assign eng_gnt_o     = eng_pend && !host_gnt_o;

    // Starvation count: grows while the host beats a pending engine word, clears otherwise.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        starve_d = starve_q;
        if (!run_i || eng_gnt_o) begin
            starve_d = '0;
        end else if (host_gnt_o && eng_pend && (starve_q != LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use <= so every flop samples pre-edge values regardless of block order.
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
endmodule

// File: rtl/fb_write_sched.sv
// Framebuffer write scheduler: shares the RAM write port between Avalon host
// writes and a fill/clear engine, optionally deferring engine commands to vblank.
module fb_write_sched #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int FB_WORDS     = fb_pkg::FB_WORDS,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    fb_write_sched_if.slave   host,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic              cmd_sync,
    input  logic [ADDR_W-1:0] cmd_start,
    input  logic [ADDR_W:0]   cmd_count,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              vblank_start,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import fb_pkg::*;

    // One extra address bit lets start+count run past the end without wrapping.
    localparam logic [ADDR_W:0] FB_END   = (ADDR_W + 1)'(FB_WORDS);
    localparam logic [ADDR_W:0] ONE_WORD = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   addr_q;
    logic [ADDR_W:0]   cnt_q;
    op_e               op_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic              done_q, done_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [DATA_W-1:0] fb_wdata_q, fb_wdata_d;

    logic accept;
    logic in_run;
    logic clip;
    logic eng_req;
    logic host_req;
    logic host_gnt;
    logic eng_gnt;
    logic waitreq;

    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign in_run    = (state_q == RUN);
    assign clip      = in_run && (cnt_q != '0) && (addr_q >= FB_END);
    assign eng_req   = in_run && (cnt_q != '0) && (addr_q < FB_END);
    assign host_req  = host.chipselect && host.write;

    fb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant (
        .clk           (clk),
        .rst           (reset),
        .run_i         (in_run),
        .host_req_i    (host_req),
        .eng_req_i     (eng_req),
        .waitrequest_o (waitreq),
        .host_gnt_o    (host_gnt),
        .eng_gnt_o     (eng_gnt)
    );

    assign host.waitrequest = waitreq;

    // Command FSM next state; done pulses on every return to IDLE from a command.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_sync)               state_d = WAIT_VBL;
                    else if (cmd_count == '0)   done_d  = 1'b1;  // nothing to write
                    else                        state_d = RUN;
                end
            end
            WAIT_VBL: begin
                if (vblank_start) state_d = RUN;
            end
            RUN: begin
                if ((cnt_q == '0) || clip || (eng_gnt && (cnt_q == ONE_WORD))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM port mux: the granted side drives the next registered write; otherwise hold.
    always_comb begin
        fb_we_d    = 1'b0;
        fb_addr_d  = fb_addr_q;
        fb_wdata_d = fb_wdata_q;
        if (host_gnt) begin
            fb_we_d    = 1'b1;
            fb_addr_d  = host.address;
            fb_wdata_d = host.writedata;
        end else if (eng_gnt) begin
            fb_we_d    = 1'b1;
            fb_addr_d  = addr_q[ADDR_W-1:0];
            fb_wdata_d = (op_q == OP_FILL) ? data_q : '0;
        end
    end

    // FSM state, latched command fields and sticky clip flag.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: there is no storage array here, so every register, wide data included, gets a reset value.
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            op_q    <= OP_CLEAR;
            data_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (accept) begin
                addr_q <= {1'b0, cmd_start};
                cnt_q  <= cmd_count;
                op_q   <= op_e'(cmd_op);
                data_q <= cmd_data;
                err_q  <= 1'b0;
            end else begin
                if (eng_gnt) begin
                    addr_q <= addr_q + ONE_WORD;
                    cnt_q  <= cnt_q - ONE_WORD;
                end
                if (clip) err_q <= 1'b1;
            end
        end
    end

    // Registered RAM write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
        end else begin
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_wdata_q <= fb_wdata_d;
        end
    end

    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_wdata = fb_wdata_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
endmodule

// File: tb/tb_fb_write_sched.sv
// Self-checking bench for fb_write_sched: per-source scoreboards for host and
// engine RAM writes plus cycle-accurate timing checks per scenario.
module tb_fb_write_sched;
    import fb_pkg::*;

    typedef struct packed {
        logic [14:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic        cmd_sync;
    logic [14:0] cmd_start;
    logic [15:0] cmd_count;
    logic [31:0] cmd_data;
    logic        vblank_start;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [31:0] fb_wdata;
    logic        busy;
    logic        done;
    logic        err;

    fb_write_sched_if #(.ADDR_W(15), .DATA_W(32)) host_if ();

    fb_write_sched #(
        .ADDR_W       (15),
        .DATA_W       (32),
        .FB_WORDS     (9600),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .host         (host_if),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_sync     (cmd_sync),
        .cmd_start    (cmd_start),
        .cmd_count    (cmd_count),
        .cmd_data     (cmd_data),
        .vblank_start (vblank_start),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_wdata     (fb_wdata),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  vectors     = 0;
    int  miscompares = 0;
    wr_t eng_q[$];
    wr_t host_q[$];
    int  eng_lo = 0;
    int  eng_hi = 0;

    // Results of run_cmd, cycle numbers relative to the accept cycle (0).
    int   r_first, r_last, r_neng, r_done, r_ndone, r_nwr, r_wr_off;
    logic r_accept, r_busy1, r_busy_done, r_ready_done, r_err_done;

    // Scoreboard monitor: every RAM write must match the head of its source queue.
    always @(negedge clk) begin
        wr_t got;
        wr_t exp;
        if (!reset && fb_we) begin
            got = '{addr: fb_addr, data: fb_wdata};
            vectors++;
            if (int'(fb_addr) >= eng_lo && int'(fb_addr) < eng_hi) begin
                if (eng_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL eng_write unexpected addr=%0d data=%h", fb_addr, fb_wdata);
                end else begin
                    exp = eng_q.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL eng_write got addr=%0d data=%h want addr=%0d data=%h",
                                 got.addr, got.data, exp.addr, exp.data);
                    end
                end
            end else begin
                if (host_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL host_write unexpected addr=%0d data=%h", fb_addr, fb_wdata);
                end else begin
                    exp = host_q.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL host_write got addr=%0d data=%h want addr=%0d data=%h",
                                 got.addr, got.data, exp.addr, exp.data);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid            = 1'b0;
        vblank_start         = 1'b0;
        host_if.chipselect   = 1'b0;
        host_if.write        = 1'b0;
        host_if.address      = '0;
        host_if.writedata    = '0;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (3) begin
            @(negedge clk);
            step();
        end
    endtask

    // Issue one engine command at cycle 0 and observe it; optional continuous host writes.
    task automatic run_cmd(input logic op, input logic sync, input int start, input int count,
                           input logic [31:0] data, input bit host_on, input int vbl_at,
                           input int max_cyc);
        int          hk;
        bit          pend;
        logic [14:0] ha;
        logic [31:0] hd;
        r_first = -1; r_last = -1; r_neng = 0; r_done = -1; r_ndone = 0;
        r_nwr = 0; r_wr_off = 0; r_accept = 1'b0; r_busy1 = 1'b0;
        r_busy_done = 1'bx; r_ready_done = 1'bx; r_err_done = 1'bx;
        eng_lo = start;
        eng_hi = start + count;
        for (int a = start; a < start + count && a < FB_WORDS; a++)
            eng_q.push_back('{addr: 15'(a), data: (op ? data : 32'h0)});
        cmd_op    = op;
        cmd_sync  = sync;
        cmd_start = 15'(start);
        cmd_count = 16'(count);
        cmd_data  = data;
        hk = 0; pend = 1'b0; ha = '0; hd = '0;
        for (int c = 0; c <= max_cyc; c++) begin
            cmd_valid    = (c == 0);
            vblank_start = sync && (c == 0 || c == vbl_at);
            if (host_on) begin
                if (!pend) begin
                    ha = (hk % 7 == 3) ? 15'(9700 + hk) : 15'(5000 + hk);
                    hd = 32'hC0DE_0000 + 32'(hk);
                    host_q.push_back('{addr: ha, data: hd});
                    pend = 1'b1;
                    hk++;
                end
                host_if.chipselect = 1'b1;
                host_if.write      = 1'b1;
                host_if.address    = ha;
                host_if.writedata  = hd;
            end
            @(negedge clk);
            if (c == 0) r_accept = cmd_ready;
            if (c == 1) r_busy1 = busy;
            if (pend && !host_if.waitrequest) pend = 1'b0;
            if (host_if.waitrequest) begin
                r_nwr++;
                if (c % 5 != 0) r_wr_off++;
            end
            if (fb_we && int'(fb_addr) >= eng_lo && int'(fb_addr) < eng_hi) begin
                r_neng++;
                if (r_first < 0) r_first = c;
                r_last = c;
            end
            if (done) begin
                r_ndone++;
                if (r_done < 0) begin
                    r_done       = c;
                    r_busy_done  = busy;
                    r_ready_done = cmd_ready;
                    r_err_done   = err;
                end
            end
            step();
            if (r_done >= 0 && c >= r_done + 3) break;
        end
        drain();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) step();
        @(negedge clk);
        vectors++; if (fb_we !== 1'b0)    begin miscompares++; $display("FAIL reset_fb_we got=%b want=0", fb_we); end
        vectors++; if (fb_addr !== '0)    begin miscompares++; $display("FAIL reset_fb_addr got=%0d want=0", fb_addr); end
        vectors++; if (fb_wdata !== '0)   begin miscompares++; $display("FAIL reset_fb_wdata got=%h want=0", fb_wdata); end
        vectors++; if (host_if.waitrequest !== 1'b0) begin miscompares++; $display("FAIL reset_waitrequest got=%b want=0", host_if.waitrequest); end
        vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
        vectors++; if (done !== 1'b0)     begin miscompares++; $display("FAIL reset_done got=%b want=0", done); end
        vectors++; if (err !== 1'b0)      begin miscompares++; $display("FAIL reset_err got=%b want=0", err); end
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_clear_full();
        run_cmd(1'b0, 1'b0, 0, 9600, 32'hA5A5_A5A5, 1'b0, 0, 9700);
        vectors++; if (r_accept !== 1'b1) begin miscompares++; $display("FAIL clear_accept got=%b want=1", r_accept); end
        vectors++; if (r_first != 2)      begin miscompares++; $display("FAIL clear_first_we got=%0d want=2", r_first); end
        vectors++; if (r_neng != 9600)    begin miscompares++; $display("FAIL clear_nwrites got=%0d want=9600", r_neng); end
        vectors++; if (r_done != 9601)    begin miscompares++; $display("FAIL clear_done_cycle got=%0d want=9601", r_done); end
        vectors++; if (r_last != 9601)    begin miscompares++; $display("FAIL clear_last_we got=%0d want=9601", r_last); end
        vectors++; if (r_busy_done !== 1'b0)  begin miscompares++; $display("FAIL clear_busy_at_done got=%b want=0", r_busy_done); end
        vectors++; if (r_ready_done !== 1'b1) begin miscompares++; $display("FAIL clear_ready_at_done got=%b want=1", r_ready_done); end
        vectors++; if (r_err_done !== 1'b0)   begin miscompares++; $display("FAIL clear_err got=%b want=0", r_err_done); end
        vectors++; if (r_ndone != 1)      begin miscompares++; $display("FAIL clear_done_pulses got=%0d want=1", r_ndone); end
        vectors++; if (eng_q.size() != 0) begin miscompares++; $display("FAIL clear_eng_left got=%0d want=0", eng_q.size()); end
    endtask

    task automatic test_host_contention();
        run_cmd(1'b1, 1'b0, 20, 20, 32'hFFFF_FFFF, 1'b1, 0, 200);
        vectors++; if (r_nwr != 20)       begin miscompares++; $display("FAIL host_wr_cycles got=%0d want=20", r_nwr); end
        vectors++; if (r_wr_off != 0)     begin miscompares++; $display("FAIL host_wr_offpattern got=%0d want=0", r_wr_off); end
        vectors++; if (r_neng != 20)      begin miscompares++; $display("FAIL host_eng_writes got=%0d want=20", r_neng); end
        vectors++; if (r_first != 6)      begin miscompares++; $display("FAIL host_first_eng got=%0d want=6", r_first); end
        vectors++; if (r_done != 101)     begin miscompares++; $display("FAIL host_done_cycle got=%0d want=101", r_done); end
        vectors++; if (host_q.size() != 0) begin miscompares++; $display("FAIL host_writes_lost got=%0d want=0", host_q.size()); end
        vectors++; if (eng_q.size() != 0) begin miscompares++; $display("FAIL host_eng_left got=%0d want=0", eng_q.size()); end
    endtask

    task automatic test_sync();
        run_cmd(1'b1, 1'b1, 1000, 20, 32'h0F0F_1234, 1'b0, 100, 200);
        vectors++; if (r_busy1 !== 1'b1)  begin miscompares++; $display("FAIL sync_busy_waiting got=%b want=1", r_busy1); end
        vectors++; if (r_first != 102)    begin miscompares++; $display("FAIL sync_first_we got=%0d want=102", r_first); end
        vectors++; if (r_neng != 20)      begin miscompares++; $display("FAIL sync_nwrites got=%0d want=20", r_neng); end
        vectors++; if (r_done != 121)     begin miscompares++; $display("FAIL sync_done_cycle got=%0d want=121", r_done); end
        vectors++; if (eng_q.size() != 0) begin miscompares++; $display("FAIL sync_eng_left got=%0d want=0", eng_q.size()); end
    endtask

    task automatic test_clip();
        run_cmd(1'b1, 1'b0, 9590, 20, 32'hDEAD_BEEF, 1'b0, 0, 100);
        vectors++; if (r_neng != 10)      begin miscompares++; $display("FAIL clip_nwrites got=%0d want=10", r_neng); end
        vectors++; if (r_last != 11)      begin miscompares++; $display("FAIL clip_last_we got=%0d want=11", r_last); end
        vectors++; if (r_done != 12)      begin miscompares++; $display("FAIL clip_done_cycle got=%0d want=12", r_done); end
        vectors++; if (r_err_done !== 1'b1)  begin miscompares++; $display("FAIL clip_err got=%b want=1", r_err_done); end
        vectors++; if (r_busy_done !== 1'b0) begin miscompares++; $display("FAIL clip_busy got=%b want=0", r_busy_done); end
        vectors++; if (err !== 1'b1)      begin miscompares++; $display("FAIL clip_err_sticky got=%b want=1", err); end
        vectors++; if (eng_q.size() != 0) begin miscompares++; $display("FAIL clip_eng_left got=%0d want=0", eng_q.size()); end
    endtask

    task automatic test_count_zero();
        logic rd0, rd1, dn1, er1, we1;
        int   first, done_c, neng, ndone;
        eng_lo = 300;
        eng_hi = 303;
        for (int i = 0; i < 3; i++) eng_q.push_back('{addr: 15'(300 + i), data: 32'h1234_5678});
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_sync = 1'b0;
        cmd_start = 15'd300; cmd_count = 16'd0; cmd_data = 32'h1234_5678;
        @(negedge clk);
        rd0 = cmd_ready;
        step();
        cmd_count = 16'd3;
        @(negedge clk);
        rd1 = cmd_ready; dn1 = done; er1 = err; we1 = fb_we;
        step();
        cmd_valid = 1'b0;
        first = -1; done_c = -1; neng = 0; ndone = 0;
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            if (fb_we && int'(fb_addr) >= eng_lo && int'(fb_addr) < eng_hi) begin
                neng++;
                if (first < 0) first = c;
            end
            if (done) begin
                ndone++;
                done_c = c;
            end
            step();
        end
        drain();
        vectors++; if (rd0 !== 1'b1)   begin miscompares++; $display("FAIL zero_accept got=%b want=1", rd0); end
        vectors++; if (dn1 !== 1'b1)   begin miscompares++; $display("FAIL zero_done_t1 got=%b want=1", dn1); end
        vectors++; if (rd1 !== 1'b1)   begin miscompares++; $display("FAIL zero_second_accept got=%b want=1", rd1); end
        vectors++; if (er1 !== 1'b0)   begin miscompares++; $display("FAIL zero_err_cleared got=%b want=0", er1); end
        vectors++; if (we1 !== 1'b0)   begin miscompares++; $display("FAIL zero_no_write got=%b want=0", we1); end
        vectors++; if (first != 3)     begin miscompares++; $display("FAIL zero_second_first_we got=%0d want=3", first); end
        vectors++; if (done_c != 5)    begin miscompares++; $display("FAIL zero_second_done got=%0d want=5", done_c); end
        vectors++; if (neng != 3)      begin miscompares++; $display("FAIL zero_second_nwrites got=%0d want=3", neng); end
        vectors++; if (ndone != 1)     begin miscompares++; $display("FAIL zero_second_pulses got=%0d want=1", ndone); end
        vectors++; if (eng_q.size() != 0) begin miscompares++; $display("FAIL zero_eng_left got=%0d want=0", eng_q.size()); end
    endtask

    task automatic test_reset_mid_run();
        int   neng, ndone_after, eng_after, not_ready;
        eng_lo = 200;
        eng_hi = 300;
        for (int i = 0; i < 50; i++) eng_q.push_back('{addr: 15'(200 + i), data: 32'h1357_9BDF});
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_sync = 1'b0;
        cmd_start = 15'd200; cmd_count = 16'd100; cmd_data = 32'h1357_9BDF;
        @(negedge clk);
        step();
        cmd_valid = 1'b0;
        neng = 0;
        for (int c = 1; c <= 51; c++) begin
            @(negedge clk);
            if (fb_we && int'(fb_addr) >= eng_lo && int'(fb_addr) < eng_hi) neng++;
            step();
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (neng != 50)      begin miscompares++; $display("FAIL abort_words_before got=%0d want=50", neng); end
        vectors++; if (fb_we !== 1'b0)  begin miscompares++; $display("FAIL abort_fb_we got=%b want=0", fb_we); end
        vectors++; if (fb_addr !== '0)  begin miscompares++; $display("FAIL abort_fb_addr got=%0d want=0", fb_addr); end
        vectors++; if (fb_wdata !== '0) begin miscompares++; $display("FAIL abort_fb_wdata got=%h want=0", fb_wdata); end
        vectors++; if (busy !== 1'b0)   begin miscompares++; $display("FAIL abort_busy got=%b want=0", busy); end
        vectors++; if (done !== 1'b0)   begin miscompares++; $display("FAIL abort_done got=%b want=0", done); end
        step();
        step();
        reset = 1'b0;
        host_if.chipselect = 1'b1;
        host_if.write      = 1'b1;
        host_if.address    = 15'd9700;
        host_if.writedata  = 32'hFACE_0001;
        host_q.push_back('{addr: 15'd9700, data: 32'hFACE_0001});
        ndone_after = 0; eng_after = 0; not_ready = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) ndone_after++;
            if (!cmd_ready) not_ready++;
            if (fb_we && int'(fb_addr) >= eng_lo && int'(fb_addr) < eng_hi) eng_after++;
            step();
            idle_inputs();
        end
        drain();
        vectors++; if (ndone_after != 0) begin miscompares++; $display("FAIL abort_no_done got=%0d want=0", ndone_after); end
        vectors++; if (eng_after != 0)   begin miscompares++; $display("FAIL abort_no_eng got=%0d want=0", eng_after); end
        vectors++; if (not_ready != 0)   begin miscompares++; $display("FAIL abort_cmd_ready got=%0d want=0", not_ready); end
        vectors++; if (host_q.size() != 0) begin miscompares++; $display("FAIL abort_host_path got=%0d want=0", host_q.size()); end
        vectors++; if (eng_q.size() != 0)  begin miscompares++; $display("FAIL abort_eng_left got=%0d want=0", eng_q.size()); end
    endtask

    initial begin
        cmd_op = 1'b0; cmd_sync = 1'b0; cmd_start = '0; cmd_count = '0; cmd_data = '0;
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_clear_full();
        test_host_contention();
        test_sync();
        test_clip();
        test_count_zero();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fb_write_sched.md
# fb_write_sched

Write scheduler for the 640x480 1-bpp framebuffer (9600 32-bit words, 20 words per row). It sits between the Avalon-MM host write port and the framebuffer RAM write port. It shares that port between host writes and an internal fill/clear engine, with bounded starvation. Engine commands can be deferred to the next vertical-blank start so the fill is tear-free.

## Interface
Parameters:
- ADDR_W, 15, framebuffer word-address width
- DATA_W, 32, framebuffer word width
- FB_WORDS, 9600, number of valid word addresses
- STARVE_LIMIT, 4, consecutive host-won cycles after which the engine is guaranteed one slot

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous active-high reset
- chipselect  in  1  host Avalon select
- write  in  1  host write strobe
- address  in  ADDR_W  host word address
- writedata  in  DATA_W  host write data
- waitrequest  out  1  host stall (Avalon)
- cmd_valid  in  1  engine command offered
- cmd_ready  out  1  engine can accept a command
- cmd_op  in  1  0=CLEAR (data forced to 0), 1=FILL (cmd_data)
- cmd_sync  in  1  start only after the next vblank_start
- cmd_start  in  ADDR_W  first word address
- cmd_count  in  ADDR_W+1  number of words
- cmd_data  in  DATA_W  fill pattern
- vblank_start  in  1  one-cycle pulse from the display timing generator
- fb_we  out  1  RAM write enable (registered)
- fb_addr  out  ADDR_W  RAM address (registered)
- fb_wdata  out  DATA_W  RAM data (registered)
- busy  out  1  engine not IDLE
- done  out  1  one-cycle pulse at the end of a command
- err  out  1  sticky clip flag; cleared when the next command is accepted

## Operation
- States:
  - IDLE: cmd_ready=1.
  - IDLE→WAIT_VBL on accept with cmd_sync=1; IDLE→RUN on accept with cmd_sync=0.
  - WAIT_VBL→RUN on vblank_start. A pulse in the same cycle as the accept is ignored.
  - RUN→IDLE when the last word is granted, or on clip.
- Command fields are latched on accept (cmd_valid && cmd_ready).
- Engine address runs from cmd_start upward, incrementing by 1. Remaining count decrements on each engine grant.
- A host write is granted when chipselect && write && !waitrequest.
- Arbitration happens only in RUN; elsewhere the host always owns the RAM port.
  - The host has priority while starve_cnt < STARVE_LIMIT.
  - starve_cnt increments on each RUN cycle in which a host write wins over a pending engine word, and saturates at STARVE_LIMIT.
  - At STARVE_LIMIT, waitrequest=1 (combinational) and the engine is granted. starve_cnt then clears.
  - starve_cnt clears on every engine grant and on leaving RUN.
- Host writes with address >= FB_WORDS pass through unchanged; address decode belongs to the RAM owner.
- count=0 means no writes: RUN immediately returns to IDLE and done pulses.
- Clip: if an engine address reaches FB_WORDS, no write is issued for it. err=1, done pulses, and state returns to IDLE. Example: start=9590, count=20 gives exactly 10 writes.
- Address arithmetic is carried in ADDR_W+1 bits, so cmd_start+cmd_count has no wrap-around.

## Timing
- Reset values: fb_we=0, fb_addr=0, fb_wdata=0, waitrequest=0, busy=0, done=0, err=0, cmd_ready=1, state=IDLE, starve_cnt=0.
- Reset mid-RUN aborts the command. No further engine writes occur and no done pulse is issued.
- Latency: a grant in cycle N gives fb_we/fb_addr/fb_wdata in cycle N+1.
- Accept in cycle T with no host traffic:
  - RUN in T+1, first engine fb_we in T+2.
  - The last of k words appears in T+1+k.
  - done=1 and busy=0 in that same cycle. cmd_ready=1 from that cycle.
- Sync command: the first engine grant occurs in the cycle after vblank_start.
- Under continuous host writes in RUN: the pattern is STARVE_LIMIT host grants then one engine grant (waitrequest high one cycle in STARVE_LIMIT+1).
- In any cycle where neither side is granted, fb_we=0 and fb_addr/fb_wdata hold their previous values.

## Structure
- Package fb_pkg holds:
  - the op_e enum (OP_CLEAR, OP_FILL)
  - the state_e enum (IDLE, WAIT_VBL, RUN)
  - constants FB_WORDS=9600, WORDS_PER_ROW=20, DISPLAY_W=640, DISPLAY_H=480
- Sub-module fb_grant holds the starvation counter, grant select and waitrequest generation. The FSM, address/count registers and output registers live in fb_write_sched.

## Test plan
- CLEAR, start=0, count=9600, idle host → 9600 writes at addr 0..9599, data 0; done at T+9601; err=0.
- FILL, start=20, count=20, data=FFFFFFFF, host writing every cycle → waitrequest high every 5th cycle; 20 engine writes at addr 20..39 interleaved with host writes; no host write lost.
- FILL with cmd_sync=1, vblank_start at T+100 → no engine fb_we before T+102; first engine write at T+102.
- FILL, start=9590, count=20 → 10 writes at addr 9590..9599; err=1; done pulse; busy drops.
- count=0 → no engine fb_we; done at T+1. A second command is accepted at T+1.
- reset asserted mid-RUN at word 50 of 100 → all outputs 0 within the reset cycle; no done; after release, cmd_ready=1 and the host path works.
